sap1_program_loader: RTL

Upstream stage of the SAP-1 cpu. It accepts a framed byte stream over a valid/ready handshake from a host interface. It writes the payload into the cpu's 16x8 RAM through the programming port (pr_mode, pr_address, pr_data, pr_we). After a checksum-verified frame it releases the cpu to run; on any framing fault it holds the cpu in programming mode and flags an error.

---
 rtl/sap1_pkg.sv | 27 ++
 rtl/sap1_timeout_counter.sv | 42 ++++
 rtl/sap1_program_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 program loader and related cpu-side blocks.
package sap1_pkg;

  // RAM geometry of the SAP-1 cpu: 16 words, 4-bit address.
  localparam int RAM_DEPTH = 16;
  localparam int ADDR_W    = 4;

  // Default frame start marker.
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Loader FSM states; the encoding is visible on the debug output.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_COUNT      = 3'd1,
    ST_DATA       = 3'd2,
    ST_WRITE      = 3'd3,
    ST_CHECK_WAIT = 3'd4,
    ST_CHECK      = 3'd5,
    ST_ERROR      = 3'd6
  } state_t;

  // A frame must carry at least one word and no more than the RAM holds.
  function automatic logic count_legal(input logic [7:0] c);
    return (c != 8'd0) && (c <= 8'(RAM_DEPTH));
  endfunction

endpackage

// File: rtl/sap1_timeout_counter.sv
// Loadable down-counter used as an idle watchdog. load has priority over
// en; counting stops at zero, and expired reports that zero was reached.
module sap1_timeout_counter #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             expired
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear, reload, or decrement toward zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == '0);

endmodule

// File: rtl/sap1_program_loader.sv
// Receives a framed byte stream (SYNC, COUNT, data..., CHK) and writes the
// payload into the SAP-1 RAM through its programming port. The cpu is only
// released once the 8-bit wrap-around sum of the data matches CHK.
//
// Handshake: a byte transfers on a rising clk edge where rx_valid and
// rx_ready are both 1. rx_valid may be raised or dropped at any time;
// rx_ready depends only on the FSM state (low in WRITE and CHECK).
module sap1_program_loader
  import sap1_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              pr_mode,
  output logic [ADDR_W-1:0] pr_address,
  output logic [7:0]        pr_data,
  output logic              pr_we,
  output logic              cpu_run,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_out
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [7:0]          sum_q, sum_d;
  logic                chk_ok_q, chk_ok_d;
  logic                pr_mode_q, pr_mode_d;
  logic                cpu_run_q, cpu_run_d;
  logic                pr_we_q, pr_we_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                rx_fire;
  logic                counting;
  logic                last_word;
  logic                tmo_load;
  logic                tmo_en;
  logic                tmo_expired;
  logic [TW-1:0]       tmo_count;

  assign rx_ready  = (state_q != ST_WRITE) && (state_q != ST_CHECK);
  assign rx_fire   = rx_valid && rx_ready;
  assign counting  = (state_q == ST_COUNT) || (state_q == ST_DATA) ||
                     (state_q == ST_CHECK_WAIT);
  assign last_word = ({1'b0, addr_q} == (count_q - CNT_ONE));

  // The watchdog restarts on every accepted byte and is held loaded outside
  // the states that wait on the host, so it measures idle time only there.
  assign tmo_load = rx_fire || !counting;
  assign tmo_en   = counting && !rx_fire;

  sap1_timeout_counter #(
    .WIDTH (TW)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst),
    .clr        (1'b0),
    .load       (tmo_load),
    .load_value (TW'(TIMEOUT_CYCLES - 1)),
    .en         (tmo_en),
    .count      (tmo_count),
    .expired    (tmo_expired)
  );

  // Next-state and datapath decisions for the loader FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    count_d   = count_q;
    sum_d     = sum_q;
    chk_ok_d  = chk_ok_q;
    pr_mode_d = pr_mode_q;
    cpu_run_d = cpu_run_q;
    pr_we_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        // Non-sync bytes are swallowed; sync halts the cpu and clears err.
        if (rx_fire && (rx_data == SYNC_BYTE)) begin
          state_d   = ST_COUNT;
          pr_mode_d = 1'b1;
          cpu_run_d = 1'b0;
          err_d     = 1'b0;
        end
      end

      ST_COUNT: begin
        if (rx_fire) begin
          if (count_legal(rx_data)) begin
            count_d = rx_data[ADDR_W:0];
            sum_d   = 8'd0;
            addr_d  = '0;
            state_d = ST_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end

      ST_DATA: begin
        // Register the byte so the write strobe follows one cycle later.
        if (rx_fire) begin
          data_d  = rx_data;
          sum_d   = sum_q + rx_data;
          pr_we_d = 1'b1;
          state_d = ST_WRITE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end

      ST_WRITE: begin
        // The 4-bit address wraps after word 15, but no write follows it.
        addr_d  = addr_q + ADDR_W'(1);
        state_d = last_word ? ST_CHECK_WAIT : ST_DATA;
      end

      ST_CHECK_WAIT: begin
        if (rx_fire) begin
          chk_ok_d = (rx_data == sum_q);
          state_d  = ST_CHECK;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end

      ST_CHECK: begin
        if (chk_ok_q) begin
          pr_mode_d = 1'b0;
          cpu_run_d = 1'b1;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end

      ST_ERROR: begin
        // cpu stays halted; the host retries from IDLE.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= 8'd0;
      count_q   <= '0;
      sum_q     <= 8'd0;
      chk_ok_q  <= 1'b0;
      pr_mode_q <= 1'b1;
      cpu_run_q <= 1'b0;
      pr_we_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      chk_ok_q  <= chk_ok_d;
      pr_mode_q <= pr_mode_d;
      cpu_run_q <= cpu_run_d;
      pr_we_q   <= pr_we_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign pr_mode    = pr_mode_q;
  assign pr_address = addr_q;
  assign pr_data    = data_q;
  assign pr_we      = pr_we_q;
  assign cpu_run    = cpu_run_q;
  assign done       = done_q;
  assign err        = err_q;
  assign state_out  = state_q;

endmodule
